// File: rtl/aes256_key_scheduler.sv
// rtl/aes256_key_scheduler.sv - iterative AES-256 key schedule with 15x128 round-key file
// One shared expansion step (4 S-boxes) produces one round key per cycle.
module aes256_key_scheduler #(
  parameter int NRK             = 15,
  parameter bit ZEROIZE_ON_LOAD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load_i,
  input  logic [255:0] key_in_i,
  output logic         busy_o,
  output logic         keys_ready_o,
  input  logic         rk_req_i,
  input  logic [3:0]   rk_idx_i,
  output logic [127:0] rk_data_o,
  output logic         rk_valid_o,
  output logic         rk_err_o
);

  localparam logic [3:0] LAST = 4'(NRK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [255:0]   w_q, w_d;
  logic [3:0]     r_q;
  logic [7:0]     rcon_q;
  logic [127:0]   rk_q [NRK];
  logic [127:0]   rk_new;
  logic [31:0]    sub_in, sub_out, t0, t1, t2, t3;
  logic [127:0]   rk_data_q;
  logic           rk_valid_q, rk_err_q;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (zero maps to zero), then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Odd rounds substitute w3; even rounds substitute RotWord(w7).
  always_comb begin
    sub_in  = r_q[0] ? w_q[159:128] : {w_q[23:0], w_q[31:24]};
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (r_q[0]) begin
      t0     = w_q[127:96] ^ sub_out;
      t1     = w_q[95:64]  ^ t0;
      t2     = w_q[63:32]  ^ t1;
      t3     = w_q[31:0]   ^ t2;
      w_d    = {w_q[255:128], t0, t1, t2, t3};
      rk_new = w_d[127:0];
    end else begin
      t0     = w_q[255:224] ^ sub_out ^ {rcon_q, 24'h000000};
      t1     = w_q[223:192] ^ t0;
      t2     = w_q[191:160] ^ t1;
      t3     = w_q[159:128] ^ t2;
      w_d    = {t0, t1, t2, t3, w_q[127:0]};
      rk_new = w_d[255:128];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (key_load_i)                                state_d = EXPAND;
    else if (state_q == EXPAND && r_q == LAST)     state_d = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      r_q    <= '0;
      rcon_q <= '0;
      for (int i = 0; i < NRK; i++) rk_q[i] <= '0;
    end else if (key_load_i) begin
      if (ZEROIZE_ON_LOAD) begin
        for (int i = 2; i < NRK; i++) rk_q[i] <= '0;
      end
      rk_q[0] <= key_in_i[255:128];
      rk_q[1] <= key_in_i[127:0];
      w_q     <= key_in_i;
      r_q     <= 4'd2;
      rcon_q  <= 8'h01;
    end else if (state_q == EXPAND) begin
      rk_q[r_q] <= rk_new;
      w_q       <= w_d;
      r_q       <= r_q + 4'd1;
      if (!r_q[0]) rcon_q <= {rcon_q[6:0], 1'b0};
    end
  end

  // A load in the same cycle invalidates the key file, so the request is rejected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data_q  <= '0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
    end else begin
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      if (rk_req_i) begin
        if (state_q == DONE && !key_load_i && rk_idx_i <= LAST) begin
          rk_valid_q <= 1'b1;
          rk_data_q  <= rk_q[rk_idx_i];
        end else begin
          rk_err_q   <= 1'b1;
          rk_data_q  <= '0;
        end
      end
    end
  end

  assign busy_o       = (state_q == EXPAND);
  assign keys_ready_o = (state_q == DONE);
  assign rk_data_o    = rk_data_q;
  assign rk_valid_o   = rk_valid_q;
  assign rk_err_o     = rk_err_q;

endmodule
